norm_share_arb: RTL and testbench

- Arbitrates two requesters (integer-to-float conversion path, FP add/sub post-normalization path) onto one shared instance of the team's 32-bit unsigned combinational normalizer, Normal32u.
  - Normal32u inputs: a[31:0].
  - Normal32u outputs: b[31:0] and leftSh[4:0].
  - For a=0, Normal32u gives b=0 and leftSh=31.
- Round-robin grant, one-stage registered result, valid/ready handshake on every side.
- Sits between the F-extension execute stages and the normalizer. It is the only driver of the normalizer input.

---
 rtl/norm_share_arb.sv | 186 ++++++++++++++++++
 tb/tb_norm_share_arb.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/norm_share_arb.sv
// Round-robin arbiter sharing one 32-bit unsigned normalizer between two requesters,
// with a one-stage registered result. Optional counters enabled by NORM_SHARE_STATS_EN.
module norm_share_arb #(
  parameter int unsigned TAG_W     = 4,
  parameter bit          FIRST_GNT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [TAG_W-1:0] req0_tag,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [TAG_W-1:0] req1_tag,

`ifdef NORM_SHARE_STATS_EN
  output logic [15:0]      stat_cnt0,
  output logic [15:0]      stat_cnt1,
  output logic [15:0]      stat_zero,
  output logic [15:0]      stat_stall,
`endif

  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [4:0]       res_shift,
  output logic             res_zero,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag
);

  logic             res_valid_q, res_valid_d;
  logic [31:0]      res_data_q, res_data_d;
  logic [4:0]       res_shift_q, res_shift_d;
  logic             res_zero_q, res_zero_d;
  logic             res_src_q, res_src_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic             last_gnt_q, last_gnt_d;

  logic             take;
  logic             gnt;
  logic             any_req;
  logic             accept;

  logic [31:0]      norm_a;
  logic [31:0]      norm_b;
  logic [4:0]       norm_left_sh;
  logic             norm_found;
  logic [TAG_W-1:0] sel_tag;

  // Grant and handshake
  always_comb begin
    take    = !res_valid_q || res_ready;
    any_req = req0_valid || req1_valid;
    if (req0_valid && req1_valid) begin
      gnt = ~last_gnt_q;
    end else begin
      gnt = req1_valid;
    end
    accept     = take && any_req && !rst && !flush;
    req0_ready = accept && (gnt == 1'b0);
    req1_ready = accept && (gnt == 1'b1);
  end

  // Single normalizer input, driven only from the granted requester.
  always_comb begin
    norm_a  = gnt ? req1_data : req0_data;
    sel_tag = gnt ? req1_tag : req0_tag;
  end

  // Normalizer: count leading zeros, shift left by that count; zero gives b=0, leftSh=31.
  always_comb begin
    norm_left_sh = 5'd31;
    norm_found   = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!norm_found && norm_a[i]) begin
        norm_left_sh = 5'(31 - i);
        norm_found   = 1'b1;
      end
    end
    norm_b = norm_a << norm_left_sh;
  end

  // Result register next state; flush clears valid but leaves the payload as is.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_shift_d = res_shift_q;
    res_zero_d  = res_zero_q;
    res_src_d   = res_src_q;
    res_tag_d   = res_tag_q;
    last_gnt_d  = last_gnt_q;
    if (flush) begin
      res_valid_d = 1'b0;
    end else if (accept) begin
      res_valid_d = 1'b1;
      res_data_d  = norm_b;
      res_shift_d = norm_left_sh;
      res_zero_d  = (norm_a == 32'd0);
      res_src_d   = gnt;
      res_tag_d   = sel_tag;
      last_gnt_d  = gnt;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= 32'd0;
      res_shift_q <= 5'd0;
      res_zero_q  <= 1'b0;
      res_src_q   <= 1'b0;
      res_tag_q   <= '0;
      last_gnt_q  <= ~FIRST_GNT;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_shift_q <= res_shift_d;
      res_zero_q  <= res_zero_d;
      res_src_q   <= res_src_d;
      res_tag_q   <= res_tag_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_shift = res_shift_q;
  assign res_zero  = res_zero_q;
  assign res_src   = res_src_q;
  assign res_tag   = res_tag_q;

`ifdef NORM_SHARE_STATS_EN
  logic [15:0] stat_cnt0_q, stat_cnt0_d;
  logic [15:0] stat_cnt1_q, stat_cnt1_d;
  logic [15:0] stat_zero_q, stat_zero_d;
  logic [15:0] stat_stall_q, stat_stall_d;

  // Saturating counters; flush has no effect on them.
  always_comb begin
    stat_cnt0_d  = stat_cnt0_q;
    stat_cnt1_d  = stat_cnt1_q;
    stat_zero_d  = stat_zero_q;
    stat_stall_d = stat_stall_q;
    if (req0_ready && stat_cnt0_q != 16'hFFFF) begin
      stat_cnt0_d = stat_cnt0_q + 16'd1;
    end
    if (req1_ready && stat_cnt1_q != 16'hFFFF) begin
      stat_cnt1_d = stat_cnt1_q + 16'd1;
    end
    if (accept && (norm_a == 32'd0) && stat_zero_q != 16'hFFFF) begin
      stat_zero_d = stat_zero_q + 16'd1;
    end
    if (res_valid_q && !res_ready && stat_stall_q != 16'hFFFF) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt0_q  <= 16'd0;
      stat_cnt1_q  <= 16'd0;
      stat_zero_q  <= 16'd0;
      stat_stall_q <= 16'd0;
    end else begin
      stat_cnt0_q  <= stat_cnt0_d;
      stat_cnt1_q  <= stat_cnt1_d;
      stat_zero_q  <= stat_zero_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_cnt0  = stat_cnt0_q;
  assign stat_cnt1  = stat_cnt1_q;
  assign stat_zero  = stat_zero_q;
  assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_norm_share_arb.sv
// Directed self-checking bench for norm_share_arb (TAG_W=4, FIRST_GNT=0).
module tb_norm_share_arb;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic [3:0]  req0_tag, req1_tag;
  logic        res_valid, res_ready, res_zero, res_src;
  logic [31:0] res_data;
  logic [4:0]  res_shift;
  logic [3:0]  res_tag;
`ifdef NORM_SHARE_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1, stat_zero, stat_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  norm_share_arb #(.TAG_W(4), .FIRST_GNT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_tag   (req0_tag),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_tag   (req1_tag),
`ifdef NORM_SHARE_STATS_EN
    .stat_cnt0  (stat_cnt0),
    .stat_cnt1  (stat_cnt1),
    .stat_zero  (stat_zero),
    .stat_stall (stat_stall),
`endif
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_shift  (res_shift),
    .res_zero   (res_zero),
    .res_src    (res_src),
    .res_tag    (res_tag)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_data = 32'd0; req0_tag = 4'd0;
    req1_valid = 1'b0; req1_data = 32'd0; req1_tag = 4'd0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_result(input string tag, input logic [31:0] data, input logic [4:0] sh,
                              input logic zero, input logic src, input logic [3:0] t);
    check_eq({tag, ".valid"}, 32'(res_valid), 32'd1);
    check_eq({tag, ".data"},  res_data, data);
    check_eq({tag, ".shift"}, 32'(res_shift), 32'(sh));
    check_eq({tag, ".zero"},  32'(res_zero), 32'(zero));
    check_eq({tag, ".src"},   32'(res_src), 32'(src));
    check_eq({tag, ".tag"},   32'(res_tag), 32'(t));
  endtask

  logic exp_src;

  initial begin
    rst = 1'b1;
    res_ready = 1'b1;
    idle_inputs();
    #1;
    // Readies must be low during reset even with a valid request.
    req0_valid = 1'b1;
    #1;
    check_eq("rst_ready0", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    do_reset();
    check_eq("rst_valid", 32'(res_valid), 32'd0);
    check_eq("rst_data",  res_data, 32'd0);
    check_eq("rst_shift", 32'(res_shift), 32'd0);
    check_eq("rst_tag",   32'(res_tag), 32'd0);

    // Single request, operand 1.
    req0_valid = 1'b1; req0_data = 32'h0000_0001; req0_tag = 4'd3;
    #1;
    check_eq("single_ready0", 32'(req0_ready), 32'd1);
    check_eq("single_ready1", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    check_result("single", 32'h8000_0000, 5'd31, 1'b0, 1'b0, 4'd3);
    step();
    check_eq("drain_valid", 32'(res_valid), 32'd0);

    // Fairness from reset: both valid, grants alternate starting at FIRST_GNT.
    do_reset();
    req0_valid = 1'b1; req0_data = 32'h00F0_0000; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_data = 32'h8000_0000; req1_tag = 4'd2;
    for (int i = 0; i < 6; i++) begin
      exp_src = (i % 2 == 1);
      #1;
      check_eq("rr_ready0", 32'(req0_ready), 32'(!exp_src));
      check_eq("rr_ready1", 32'(req1_ready), 32'(exp_src));
      step();
      if (exp_src) check_result("rr_src1", 32'h8000_0000, 5'd0, 1'b0, 1'b1, 4'd2);
      else         check_result("rr_src0", 32'hF000_0000, 5'd8, 1'b0, 1'b0, 4'd1);
    end
    idle_inputs();

    // Backpressure: src 0 result held 5 cycles while req1 waits.
    do_reset();
    req0_valid = 1'b1; req0_data = 32'h00F0_0000; req0_tag = 4'd5;
    step();
    req0_valid = 1'b0;
    res_ready = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h0000_0100; req1_tag = 4'd7;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_ready1", 32'(req1_ready), 32'd0);
      check_result("bp_hold", 32'hF000_0000, 5'd8, 1'b0, 1'b0, 4'd5);
      step();
    end
    res_ready = 1'b1;
    #1;
    check_eq("bp_release_ready1", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    check_result("bp_next", 32'h8000_0000, 5'd23, 1'b0, 1'b1, 4'd7);

    // Zero operand.
    req1_valid = 1'b1; req1_data = 32'd0; req1_tag = 4'd9;
    step();
    req1_valid = 1'b0;
    check_result("zero", 32'd0, 5'd31, 1'b1, 1'b1, 4'd9);

    // Flush with a held result and a pending req0.
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0000_0005; req0_tag = 4'd4;
    flush = 1'b1;
    #1;
    check_eq("flush_ready0", 32'(req0_ready), 32'd0);
    step();
    flush = 1'b0; req0_valid = 1'b0;
    check_eq("flush_valid", 32'(res_valid), 32'd0);
    res_ready = 1'b1;

    // Reset together with flush clears everything.
    req0_valid = 1'b1; req0_data = 32'h0000_0010; req0_tag = 4'd2;
    step();
    check_result("pre_rst", 32'h8000_0000, 5'd27, 1'b0, 1'b0, 4'd2);
    rst = 1'b1; flush = 1'b1;
    #1;
    check_eq("rstflush_ready0", 32'(req0_ready), 32'd0);
    step();
    rst = 1'b0; flush = 1'b0; req0_valid = 1'b0;
    check_eq("rstflush_valid", 32'(res_valid), 32'd0);
    check_eq("rstflush_data",  res_data, 32'd0);
    check_eq("rstflush_shift", 32'(res_shift), 32'd0);
    check_eq("rstflush_src",   32'(res_src), 32'd0);
    check_eq("rstflush_tag",   32'(res_tag), 32'd0);

`ifdef NORM_SHARE_STATS_EN
    do_reset();
    idle_inputs();
    res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle_inputs();
      case (i)
        0: begin req0_valid = 1'b1; req0_data = 32'd1; end
        1: begin req0_valid = 1'b1; req0_data = 32'd0; end
        2: begin req1_valid = 1'b1; req1_data = 32'd2; end
        3: begin req1_valid = 1'b1; req1_data = 32'd3; end
        default: begin req0_valid = 1'b1; req0_data = 32'd4; end
      endcase
      step();
    end
    idle_inputs();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    res_ready = 1'b1;
    step();
    check_eq("stat_cnt0",  32'(stat_cnt0), 32'd3);
    check_eq("stat_cnt1",  32'(stat_cnt1), 32'd2);
    check_eq("stat_zero",  32'(stat_zero), 32'd1);
    check_eq("stat_stall", 32'(stat_stall), 32'd4);
    force dut.stat_cnt0_q = 16'hFFFF;
    step();
    release dut.stat_cnt0_q;
    req0_valid = 1'b1; req0_data = 32'd7;
    step();
    req0_valid = 1'b0;
    check_eq("stat_cnt0_sat", 32'(stat_cnt0), 32'h0000_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
